// File: rtl/ofdm_pkg.sv
// Shared OFDM receive-chain package: state encoding for the CP remover,
// default FFT size and the packed sc16 sample used by FFT/equalizer stages.
package ofdm_pkg;

   localparam int MAX_LOG2_DEFAULT = 12;
   localparam int SAMPLE_W         = 32;

   typedef enum logic {CP, BODY} cpr_state_t;

   typedef struct packed {
      logic signed [15:0] i;
      logic signed [15:0] q;
   } sc16_t;

endpackage

// File: rtl/ofdm_cp_remover_if.sv
// AXI-Stream sample bus (sc16 tdata, tlast, tvalid, tready).
// master drives data/last/valid; slave drives ready.
interface ofdm_cp_remover_if
   import ofdm_pkg::*;
   ();

   logic [SAMPLE_W-1:0] tdata;
   logic                tlast;
   logic                tvalid;
   logic                tready;

   modport master (
      output tdata,
      output tlast,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tlast,
      input  tvalid,
      output tready
   );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: registered outputs and registered ready.
// Ports: clk_i, rst_i (sync, high), in_* upstream side, out_* downstream side.
module axis_skid_buffer #(
   parameter int W = 33
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] in_data_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   output logic [W-1:0] out_data_o,
   output logic         out_valid_o,
   input  logic         out_ready_i
);

   logic [W-1:0] out_data_q;
   logic         out_valid_q;
   logic [W-1:0] skid_data_q;
   logic         skid_valid_q;
   logic         push;

   // Ready only depends on the skid register, so no ready path passes through.
   assign in_ready_o  = ~skid_valid_q;
   assign push        = in_valid_i & ~skid_valid_q;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
      end else if (!out_valid_q || out_ready_i) begin
         if (skid_valid_q) begin
            out_data_q   <= skid_data_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else begin
            out_valid_q <= push;
            if (push) begin
               out_data_q <= in_data_i;
            end
         end
      end else if (push) begin
         // Output stalled: park the beat that was already accepted.
         skid_data_q  <= in_data_i;
         skid_valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/ofdm_cp_remover.sv
// Cyclic-prefix remover: drops cp_len samples, forwards fft_len samples per
// symbol with o_tlast on each symbol end; o_trunc flags packets ending early.
// Ports: clk, reset/clear (sync, high), fft_len/cp_len config, s_axis in,
// m_axis out, o_trunc sticky flag.
// Build option OFDM_CP_REMOVER_OREG_EN: outputs through a registered skid buffer.
module ofdm_cp_remover
   import ofdm_pkg::*;
#(
   parameter int MAX_LOG2 = MAX_LOG2_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic [MAX_LOG2:0]   fft_len,
   input  logic [MAX_LOG2:0]   cp_len,
   ofdm_cp_remover_if.slave    s_axis,
   ofdm_cp_remover_if.master   m_axis,
   output logic                o_trunc
);

   localparam logic [MAX_LOG2:0] ONE = {{MAX_LOG2{1'b0}}, 1'b1};

   logic              rst;
   cpr_state_t        state_q, state_d;
   logic [MAX_LOG2:0] cnt_q, cnt_d;
   logic              sop_q, sop_d;
   logic              trunc_q, trunc_d;
   logic [MAX_LOG2:0] fft_q, cp_q;
   logic [MAX_LOG2:0] fft_fix, fft_cur, cp_cur;
   logic              body_beat, sym_end, cp_end;
   logic              accept, acc_last, acc_body, acc_cp;
   sc16_t             dn_data;
   logic              dn_last, dn_valid, dn_ready;

   assign rst = reset | clear;

   // First beat of a packet uses the live config; it is latched on that beat.
   assign fft_fix = (fft_len == '0) ? ONE : fft_len;
   assign fft_cur = sop_q ? fft_fix : fft_q;
   assign cp_cur  = sop_q ? cp_len  : cp_q;

   // A zero-length prefix turns every CP beat into a body beat.
   assign body_beat = (state_q == BODY) || (cp_cur == '0);
   assign sym_end   = (cnt_q == fft_cur - ONE);
   assign cp_end    = (cnt_q == cp_cur - ONE);

   assign dn_data  = s_axis.tdata;
   assign dn_valid = s_axis.tvalid & body_beat;
   assign dn_last  = body_beat & (sym_end | s_axis.tlast);

   assign s_axis.tready = body_beat ? dn_ready : 1'b1;

   assign accept   = s_axis.tvalid & s_axis.tready;
   assign acc_last = accept & s_axis.tlast;
   assign acc_body = accept & ~s_axis.tlast & body_beat;
   assign acc_cp   = accept & ~s_axis.tlast & ~body_beat;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sop_d   = sop_q;
      trunc_d = trunc_q;
      unique case (1'b1)
         acc_last: begin
            state_d = CP;
            cnt_d   = '0;
            sop_d   = 1'b1;
            if (body_beat ? !sym_end : (cnt_q != '0)) begin
               trunc_d = 1'b1;
            end
         end
         acc_body: begin
            sop_d = 1'b0;
            if (sym_end) begin
               state_d = CP;
               cnt_d   = '0;
            end else begin
               state_d = BODY;
               cnt_d   = cnt_q + ONE;
            end
         end
         acc_cp: begin
            sop_d = 1'b0;
            if (cp_end) begin
               state_d = BODY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CP;
         cnt_q   <= '0;
         sop_q   <= 1'b1;
         trunc_q <= 1'b0;
         fft_q   <= fft_fix;
         cp_q    <= cp_len;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sop_q   <= sop_d;
         trunc_q <= trunc_d;
         if (accept && sop_q) begin
            fft_q <= fft_cur;
            cp_q  <= cp_cur;
         end
      end
   end

   assign o_trunc = trunc_q;

`ifdef OFDM_CP_REMOVER_OREG_EN
   logic [SAMPLE_W:0] skid_out;

   axis_skid_buffer #(
      .W (SAMPLE_W + 1)
   ) u_skid (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_data_i   ({dn_last, dn_data}),
      .in_valid_i  (dn_valid),
      .in_ready_o  (dn_ready),
      .out_data_o  (skid_out),
      .out_valid_o (m_axis.tvalid),
      .out_ready_i (m_axis.tready)
   );

   assign m_axis.tlast = skid_out[SAMPLE_W];
   assign m_axis.tdata = skid_out[SAMPLE_W-1:0];
`else
   assign dn_ready      = m_axis.tready;
   assign m_axis.tvalid = dn_valid;
   assign m_axis.tlast  = dn_last;
   assign m_axis.tdata  = dn_data;
`endif

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Directed bench for ofdm_cp_remover: table of packet cases plus
// hand sequences for backpressure, config change and mid-packet clear.
module tb_ofdm_cp_remover;
   import ofdm_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [12:0] fft_len;
   logic [12:0] cp_len;
   logic        o_trunc;

   ofdm_cp_remover_if s_if ();
   ofdm_cp_remover_if m_if ();

   ofdm_cp_remover #(
      .MAX_LOG2 (12)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .fft_len (fft_len),
      .cp_len  (cp_len),
      .s_axis  (s_if.slave),
      .m_axis  (m_if.master),
      .o_trunc (o_trunc)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int tr_mode = 0;

   logic [32:0] got_q[$];
   logic [32:0] exp_q[$];

   // 0: ready high, 1: random 50%, 2: held low
   always @(posedge clk) begin
      #1;
      case (tr_mode)
         0:       m_if.tready = 1'b1;
         1:       m_if.tready = 1'($urandom_range(0, 1));
         default: m_if.tready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (m_if.tvalid && m_if.tready && !reset && !clear)
         got_q.push_back({m_if.tlast, m_if.tdata});
   end

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      int  cyc;
      logic acc;
      cyc = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = last;
      forever begin
         @(negedge clk);
         acc = s_if.tready;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) break;
         if (cyc > 200) begin
            chk("send_timeout", cyc, 0);
            break;
         end
      end
      s_if.tvalid = 1'b0;
   endtask

   task automatic send_range(input int from, input int to, input bit last_end);
      for (int k = from; k <= to; k++)
         send(32'(k), last_end && (k == to));
   endtask

   task automatic do_clear();
      clear       = 1'b1;
      s_if.tvalid = 1'b0;
      @(posedge clk);
      #1;
      clear = 1'b0;
      got_q.delete();
   endtask

   // Reference: position in the (cp + fft) period decides keep/last.
   task automatic build_exp(input int n, input int base, input int fft,
                            input int cp);
      int fe;
      int per;
      int p;
      fe  = (fft == 0) ? 1 : fft;
      per = cp + fe;
      for (int k = 0; k < n; k++) begin
         p = k % per;
         if (p >= cp)
            exp_q.push_back({((p == per - 1) || (k == n - 1)), 32'(base + k)});
      end
   endtask

   task automatic cmp_stream(input string name);
      int bad;
      int m;
      bad = 0;
      chk({name, " count"}, got_q.size(), exp_q.size());
      m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < m; i++)
         if (got_q[i] !== exp_q[i]) bad++;
      chk({name, " data"}, bad, 0);
      got_q.delete();
      exp_q.delete();
   endtask

   typedef struct {
      int fft;
      int cp;
      int n;
      int bp;
      int n_out;
      int n_last;
      int trunc;
   } vec_t;

   vec_t tab[9];

   initial begin
      int lasts;
      string nm;

      tab[0] = '{64, 16,   80, 0,   64,  1, 0};
      tab[1] = '{64, 16, 2304, 0, 1840, 29, 1};
      tab[2] = '{ 4,  0,    8, 0,    8,  2, 0};
      tab[3] = '{64, 16,   80, 1,   64,  1, 0};
      tab[4] = '{ 8,  4,   10, 0,    6,  1, 1};
      tab[5] = '{ 4,  4,   10, 0,    4,  1, 1};
      tab[6] = '{ 4,  4,    8, 0,    4,  1, 0};
      tab[7] = '{ 4,  4,    9, 0,    4,  1, 0};
      tab[8] = '{ 0,  0,    3, 0,    3,  3, 0};

      reset       = 1'b1;
      clear       = 1'b0;
      fft_len     = 13'd64;
      cp_len      = 13'd16;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("reset o_tvalid", int'(m_if.tvalid), 0);
      chk("reset o_trunc", int'(o_trunc), 0);
      chk("reset i_tready", int'(s_if.tready), 1);
      @(posedge clk);
      #1;

      foreach (tab[t]) begin
         fft_len = 13'(tab[t].fft);
         cp_len  = 13'(tab[t].cp);
         do_clear();
         tr_mode = tab[t].bp;
         send_range(0, tab[t].n - 1, 1'b1);
         tr_mode = 0;
         repeat (2) @(posedge clk);
         #1;
         lasts = 0;
         foreach (got_q[i]) if (got_q[i][32]) lasts++;
         nm = $sformatf("case%0d", t);
         chk({nm, " n_out"}, got_q.size(), tab[t].n_out);
         chk({nm, " n_last"}, lasts, tab[t].n_last);
         chk({nm, " trunc"}, int'(o_trunc), tab[t].trunc);
         build_exp(tab[t].n, 0, tab[t].fft, tab[t].cp);
         cmp_stream(nm);
      end

      // Prefix beats accepted while downstream is stalled.
      fft_len = 13'd64;
      cp_len  = 13'd16;
      do_clear();
      tr_mode     = 2;
      m_if.tready = 1'b0;
      begin
         time t0;
         t0 = $time;
         send_range(0, 15, 1'b0);
         chk("cp_low cycles", int'(($time - t0) / 10), 16);
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'd16;
      s_if.tlast  = 1'b0;
      #1;
      chk("stall i_tready", int'(s_if.tready), 0);
      chk("stall o_tvalid", int'(m_if.tvalid), 1);
      chk("stall o_tdata", int'(m_if.tdata), 16);
      repeat (3) @(posedge clk);
      #1;
      chk("stall no output", got_q.size(), 0);
      tr_mode     = 0;
      m_if.tready = 1'b1;
      send_range(16, 79, 1'b1);
      build_exp(80, 0, 64, 16);
      cmp_stream("stall stream");

      // cp_len change mid-packet applies from the next packet.
      do_clear();
      send_range(0, 10, 1'b0);
      cp_len = 13'd8;
      send_range(11, 159, 1'b1);
      send_range(1000, 1143, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      build_exp(160, 0, 64, 16);
      build_exp(144, 1000, 64, 8);
      cmp_stream("cfgchg");
      chk("cfgchg trunc", int'(o_trunc), 0);

      // Clear mid-body drops trunc and restarts with a prefix.
      cp_len = 13'd16;
      do_clear();
      send_range(0, 19, 1'b1);
      @(posedge clk);
      #1;
      chk("pre-clear trunc", int'(o_trunc), 1);
      send_range(0, 40, 1'b0);
      do_clear();
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'd41;
      s_if.tlast  = 1'b0;
      #1;
      chk("clear o_tvalid", int'(m_if.tvalid), 0);
      chk("clear o_trunc", int'(o_trunc), 0);
      @(posedge clk);
      #1;
      send_range(42, 120, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      build_exp(80, 41, 64, 16);
      cmp_stream("clear stream");
      chk("clear trunc end", int'(o_trunc), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
